// File: rtl/param_load_sequencer.sv
// rtl/param_load_sequencer.sv - addressed, counted burst loader for the parameter register bank
module param_load_sequencer #(
  parameter int NUM_PARAMS = 8,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load_params,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PARAMS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              load_q, load_d;
  logic              armed_q, armed_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              start;

  // armed_q blocks a start until load_params has been seen low, so a request
  // still held high across a reset cannot re-launch a burst on its own.
  assign start = load_params & ~load_q & armed_q & enable;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    load_d    = load_q;
    armed_d   = armed_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;

    if (enable) begin
      load_d  = load_params;
      armed_d = armed_q | ~load_params;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          index_d   = '0;
          aborted_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (enable) begin
          // A falling request takes priority over a beat in the same cycle.
          if (!load_params) begin
            state_d   = S_IDLE;
            index_d   = '0;
            aborted_d = 1'b1;
          end else if (data_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = index_q;
            wr_data_d = data_in;
            if (index_q == LAST_IDX) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              index_d = '0;
            end else begin
              index_d = index_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (enable) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (enable && !load_params) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        index_d = '0;
      end
    endcase

    busy_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      load_q    <= 1'b0;
      armed_q   <= ~load_params;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      load_q    <= load_d;
      armed_q   <= armed_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_param_load_sequencer.sv
// tb/tb_param_load_sequencer.sv - directed bench for param_load_sequencer
module tb_param_load_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       load_params;
  logic [7:0] data_in;
  logic       data_valid;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       aborted;

  int checks = 0;
  int errors = 0;

  param_load_sequencer #(.NUM_PARAMS(8), .DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load_params(load_params),
    .data_in(data_in), .data_valid(data_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted beat and check the write that follows it.
  task automatic beat(input string tag, input logic [2:0] addr, input logic [7:0] d, input logic last);
    data_in = d;
    data_valid = 1'b1;
    step();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL %s_wr_en addr %0d: got %b want 1", tag, addr, wr_en); end
    checks++; if (wr_addr !== addr) begin errors++; $display("FAIL %s_wr_addr: got %0d want %0d", tag, wr_addr, addr); end
    checks++; if (wr_data !== d) begin errors++; $display("FAIL %s_wr_data addr %0d: got %h want %h", tag, addr, wr_data, d); end
    checks++; if (done !== last) begin errors++; $display("FAIL %s_done addr %0d: got %b want %b", tag, addr, done, last); end
    checks++; if (busy !== ~last) begin errors++; $display("FAIL %s_busy addr %0d: got %b want %b", tag, addr, busy, ~last); end
  endtask

  task automatic close_burst();
    data_valid = 1'b0;
    load_params = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load_params = 1'b0; data_in = 8'h00; data_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b want 0", aborted); end
  endtask

  task automatic test_back_to_back();
    load_params = 1'b1;
    data_in = 8'hFF;
    data_valid = 1'b1;
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL b2b_start_beat_ignored: got %b want 0", wr_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) beat("b2b", 3'(i), 8'((i + 1) * 17), i == 7);
    data_valid = 1'b0;
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL b2b_after_wr_en: got %b want 0", wr_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_after_done: got %b want 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL b2b_aborted: got %b want 0", aborted); end
    close_burst();
  endtask

  task automatic test_sparse();
    load_params = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      beat("sparse", 3'(i), 8'(8'hA0 + i), i == 7);
      data_valid = 1'b0;
      data_in = 8'h5A;
      for (int g = 0; g < 2; g++) begin
        step();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL sparse_gap_wr_en after %0d: got %b want 0", i, wr_en); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sparse_gap_done after %0d: got %b want 0", i, done); end
      end
    end
    close_burst();
  endtask

  task automatic test_abort();
    load_params = 1'b1;
    step();
    for (int i = 0; i < 3; i++) beat("abort", 3'(i), 8'(8'hC0 + i), 1'b0);
    load_params = 1'b0;
    data_in = 8'hEE;
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en: got %b want 0", wr_en); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_aborted: got %b want 1", aborted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (wr_addr !== 3'd2) begin errors++; $display("FAIL abort_addr_hold: got %0d want 2", wr_addr); end
    data_valid = 1'b0;
    step();
    load_params = 1'b1;
    step();
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_restart_clear: got %b want 0", aborted); end
    beat("abort_restart", 3'd0, 8'h55, 1'b0);
    close_burst();
  endtask

  task automatic test_abort_last();
    load_params = 1'b1;
    step();
    for (int i = 0; i < 7; i++) beat("abort_last", 3'(i), 8'(8'h60 + i), 1'b0);
    load_params = 1'b0;
    data_in = 8'h67;
    data_valid = 1'b1;
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL abort_last_wr_en: got %b want 0", wr_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_last_done: got %b want 0", done); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_last_aborted: got %b want 1", aborted); end
    close_burst();
  endtask

  task automatic test_enable_hold();
    load_params = 1'b1;
    step();
    for (int i = 0; i < 4; i++) beat("en", 3'(i), 8'(8'h30 + i), 1'b0);
    enable = 1'b0;
    data_in = 8'hEE;
    data_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL en_off_wr_en cycle %0d: got %b want 0", c, wr_en); end
      checks++; if (wr_addr !== 3'd3) begin errors++; $display("FAIL en_off_addr cycle %0d: got %0d want 3", c, wr_addr); end
      checks++; if (wr_data !== 8'h33) begin errors++; $display("FAIL en_off_data cycle %0d: got %h want 33", c, wr_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_off_busy cycle %0d: got %b want 1", c, busy); end
    end
    enable = 1'b1;
    for (int i = 4; i < 8; i++) beat("en_resume", 3'(i), 8'(8'h40 + i - 4), i == 7);
    close_burst();
  endtask

  task automatic test_wait_no_restart();
    load_params = 1'b1;
    step();
    for (int i = 0; i < 8; i++) beat("wait_burst", 3'(i), 8'(8'h80 + i), i == 7);
    data_valid = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      data_in = 8'(8'hD0 + c);
      data_valid = 1'b1;
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL wait_wr_en cycle %0d: got %b want 0", c, wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_busy cycle %0d: got %b want 0", c, busy); end
    end
    data_valid = 1'b0;
    load_params = 1'b0;
    step();
    load_params = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_restart_busy: got %b want 1", busy); end
    beat("wait_restart", 3'd0, 8'h99, 1'b0);
    close_burst();
  endtask

  task automatic test_reset_mid_burst();
    load_params = 1'b1;
    step();
    for (int i = 0; i < 6; i++) beat("rst_mid", 3'(i), 8'(8'hB0 + i), 1'b0);
    rst = 1'b1;
    data_in = 8'hB6;
    data_valid = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL rst_mid_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_mid_wr_data: got %h want 00", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_hold_wr_en cycle %0d: got %b want 0", c, wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy cycle %0d: got %b want 0", c, busy); end
    end
    data_valid = 1'b0;
    load_params = 1'b0;
    step();
    load_params = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_restart_busy: got %b want 1", busy); end
    beat("rst_restart", 3'd0, 8'h77, 1'b0);
    close_burst();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sparse();
    test_abort();
    test_abort_last();
    test_enable_hold();
    test_wait_no_restart();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
